// File: rtl/gpu_cmd_scheduler.sv
// rtl/gpu_cmd_scheduler.sv - fill/blit command FIFO and one-at-a-time issue to the GPU ops engine
module gpu_cmd_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [8:0]    cmd_x1,
    input  logic [8:0]    cmd_x2,
    input  logic [7:0]    cmd_y1,
    input  logic [7:0]    cmd_y2,
    input  logic          cmd_value,
    input  logic [8:0]    cmd_w,
    input  logic [7:0]    cmd_h,
    input  logic          flush,
    output logic [8:0]    eng_x1,
    output logic [8:0]    eng_x2,
    output logic [7:0]    eng_y1,
    output logic [7:0]    eng_y2,
    output logic          eng_fill_value,
    output logic [8:0]    eng_blit_w,
    output logic [7:0]    eng_blit_h,
    output logic          eng_start_fill,
    output logic          eng_start_blit,
    input  logic          eng_busy,
    input  logic          eng_error,
    output logic [AW:0]   queue_count,
    output logic          idle,
    output logic          done_pulse,
    output logic          err_pulse,
    output logic [7:0]    err_count
);

    // Packed queue entry: {op, x1, x2, y1, y2, value, w, h}
    localparam int EW = 2 + 9 + 9 + 8 + 8 + 1 + 9 + 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [EW-1:0]  head;
    logic [1:0]     head_op;
    logic           head_legal;
    logic           push;
    logic           pop;
    logic           done_set;
    logic           err_set;

    assign cmd_ready   = (count != (AW + 1)'(DEPTH));
    assign queue_count = count;
    assign head        = mem[rd_ptr];
    assign head_op     = head[EW-1 -: 2];
    assign head_legal  = !head_op[1];
    // A push offered in a flush cycle is dropped along with the queue contents.
    assign push        = cmd_valid && cmd_ready && !flush;
    // The engine has no reset, so never issue while it may still be draining an op.
    assign pop         = (state == IDLE) && (count != '0) && !eng_busy && !flush;
    assign idle        = (count == '0) && (state == IDLE) && !eng_busy;

    // Queue storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_x1, cmd_x2, cmd_y1, cmd_y2, cmd_value, cmd_w, cmd_h};
        end
    end

    // Queue pointers and occupancy, cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Issue FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Issue FSM next state and completion/error decisions.
    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    if (head_legal) state_next = ISSUE;
                    else            err_set    = 1'b1;
                end
            end
            ISSUE: state_next = CHECK;
            CHECK: begin
                if (eng_error) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else if (eng_busy) begin
                    state_next = RUN;
                end else begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (!eng_busy) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Engine operand registers, start pulses, status pulses and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_x1         <= '0;
            eng_x2         <= '0;
            eng_y1         <= '0;
            eng_y2         <= '0;
            eng_fill_value <= 1'b0;
            eng_blit_w     <= '0;
            eng_blit_h     <= '0;
            eng_start_fill <= 1'b0;
            eng_start_blit <= 1'b0;
            done_pulse     <= 1'b0;
            err_pulse      <= 1'b0;
            err_count      <= '0;
        end else begin
            // Operands persist after completion; only a new legal issue replaces them.
            if (pop && head_legal) begin
                {eng_x1, eng_x2, eng_y1, eng_y2, eng_fill_value, eng_blit_w, eng_blit_h}
                    <= head[EW-3:0];
            end
            eng_start_fill <= pop && head_legal && (head_op == 2'd0);
            eng_start_blit <= pop && head_legal && (head_op == 2'd1);
            done_pulse     <= done_set;
            err_pulse      <= err_set;
            if (err_set && (err_count != 8'hFF)) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// tb/tb_gpu_cmd_scheduler.sv - directed table-driven bench for gpu_cmd_scheduler
module tb_gpu_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [8:0] cmd_x1 = '0, cmd_x2 = '0, cmd_w = '0;
    logic [7:0] cmd_y1 = '0, cmd_y2 = '0, cmd_h = '0;
    logic       cmd_value = 1'b0;
    logic       flush = 1'b0;
    logic [8:0] eng_x1, eng_x2, eng_blit_w;
    logic [7:0] eng_y1, eng_y2, eng_blit_h;
    logic       eng_fill_value, eng_start_fill, eng_start_blit;
    logic       eng_busy = 1'b0;
    logic       eng_error = 1'b0;
    logic [2:0] queue_count;
    logic       idle, done_pulse, err_pulse;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;

    int model_len = 0;
    bit model_err = 1'b0;
    int busy_cnt = 0;

    int mon_starts = 0, mon_done = 0, mon_err = 0;
    int both_viol = 0, consec_viol = 0, busy_viol = 0;
    bit prev_start = 1'b0;
    logic [8:0] mon_x1 [$];

    gpu_cmd_scheduler #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .cmd_y1(cmd_y1), .cmd_y2(cmd_y2),
        .cmd_value(cmd_value), .cmd_w(cmd_w), .cmd_h(cmd_h), .flush(flush),
        .eng_x1(eng_x1), .eng_x2(eng_x2), .eng_y1(eng_y1), .eng_y2(eng_y2),
        .eng_fill_value(eng_fill_value), .eng_blit_w(eng_blit_w), .eng_blit_h(eng_blit_h),
        .eng_start_fill(eng_start_fill), .eng_start_blit(eng_start_blit),
        .eng_busy(eng_busy), .eng_error(eng_error), .queue_count(queue_count),
        .idle(idle), .done_pulse(done_pulse), .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Engine model: no reset, busy for model_len cycles after a start, or sticky error.
    always @(posedge clk) begin
        if (eng_start_fill || eng_start_blit) begin
            if (model_err) begin
                eng_error <= 1'b1;
                eng_busy  <= 1'b0;
                busy_cnt  <= 0;
            end else begin
                eng_error <= 1'b0;
                eng_busy  <= (model_len != 0);
                busy_cnt  <= model_len;
            end
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt <= 0;
            eng_busy <= 1'b0;
        end
    end

    // Protocol monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (eng_start_fill && eng_start_blit) both_viol++;
            if ((eng_start_fill || eng_start_blit) && prev_start) consec_viol++;
            if ((eng_start_fill || eng_start_blit) && eng_busy) busy_viol++;
            if (eng_start_fill || eng_start_blit) begin
                mon_starts++;
                mon_x1.push_back(eng_x1);
            end
            if (done_pulse) mon_done++;
            if (err_pulse)  mon_err++;
            prev_start = eng_start_fill || eng_start_blit;
        end else begin
            prev_start = 1'b0;
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [8:0] x1;
        logic [8:0] x2;
        logic [7:0] y1;
        logic [7:0] y2;
        logic       val;
        logic [8:0] w;
        logic [7:0] h;
        int         len;
        bit         err;
        int         exp_fill;
        int         exp_blit;
        int         exp_done;
        int         exp_err;
        int         exp_start_at;
        int         exp_errcnt;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [8:0] x1, input logic [8:0] x2,
                             input logic [7:0] y1, input logic [7:0] y2, input logic val,
                             input logic [8:0] w, input logic [7:0] h);
        cmd_op = op; cmd_x1 = x1; cmd_x2 = x2; cmd_y1 = y1; cmd_y2 = y2;
        cmd_value = val; cmd_w = w; cmd_h = h;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_starts(input int target, input int bound, input string name);
        int k;
        k = 0;
        while (mon_starts < target && k < bound) begin tick(); k++; end
        if (mon_starts < target) check({name, "_timeout"}, mon_starts, target);
    endtask

    task automatic wait_done(input int target, input int bound, input string name);
        int k;
        k = 0;
        while (mon_done < target && k < bound) begin tick(); k++; end
        if (mon_done < target) check({name, "_timeout"}, mon_done, target);
    endtask

    initial begin
        int n_fill, n_blit, n_done, n_err, start_at, base_s, base_d, k;
        bit got;
        logic [8:0] c_x1, c_x2, c_w;
        logic [7:0] c_y1, c_y2, c_h;
        logic c_val;

        //            op   x1      x2      y1     y2     val   w      h     len err fill blit done err at cnt
        vecs[0] = '{2'd0, 9'd0,   9'd3,   8'd0,  8'd1,  1'b1, 9'd0,  8'd0,  8, 1'b0, 1, 0, 1, 0,  1, 0};
        vecs[1] = '{2'd1, 9'd10,  9'd100, 8'd5,  8'd50, 1'b0, 9'd20, 8'd10, 3, 1'b0, 0, 1, 1, 0,  1, 0};
        vecs[2] = '{2'd1, 9'd200, 9'd50,  8'd7,  8'd9,  1'b0, 9'd4,  8'd2,  0, 1'b1, 0, 1, 0, 1,  1, 1};
        vecs[3] = '{2'd3, 9'd1,   9'd2,   8'd3,  8'd4,  1'b1, 9'd5,  8'd6,  4, 1'b0, 0, 0, 0, 1, -1, 2};
        vecs[4] = '{2'd0, 9'd0,   9'd511, 8'd0,  8'd255,1'b0, 9'd0,  8'd0,  0, 1'b0, 1, 0, 1, 0,  1, 2};
        vecs[5] = '{2'd2, 9'd9,   9'd9,   8'd9,  8'd9,  1'b1, 9'd9,  8'd9,  4, 1'b0, 0, 0, 0, 1, -1, 3};

        // Reset state while reset is held.
        #12;
        check("rst_eng_x2", eng_x2, 0);
        check("rst_starts", {eng_start_fill, eng_start_blit}, 0);
        check("rst_queue_count", queue_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_pulses", {done_pulse, err_pulse}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_idle", idle, 1);

        // Table: one command at a time into an empty idle queue.
        foreach (vecs[i]) begin
            model_len = vecs[i].len;
            model_err = vecs[i].err;
            drive_cmd(vecs[i].op, vecs[i].x1, vecs[i].x2, vecs[i].y1, vecs[i].y2,
                      vecs[i].val, vecs[i].w, vecs[i].h);
            tick();
            cmd_valid = 1'b0;
            n_fill = 0; n_blit = 0; n_done = 0; n_err = 0; start_at = -1; got = 1'b0;
            c_x1 = '0; c_x2 = '0; c_y1 = '0; c_y2 = '0; c_val = 1'b0; c_w = '0; c_h = '0;
            for (int j = 1; j <= 60 && !got; j++) begin
                tick();
                if (eng_start_fill || eng_start_blit) begin
                    if (start_at < 0) start_at = j;
                    c_x1 = eng_x1; c_x2 = eng_x2; c_y1 = eng_y1; c_y2 = eng_y2;
                    c_val = eng_fill_value; c_w = eng_blit_w; c_h = eng_blit_h;
                end
                n_fill += int'(eng_start_fill);
                n_blit += int'(eng_start_blit);
                if (done_pulse || err_pulse) begin
                    got = 1'b1;
                    n_done += int'(done_pulse);
                    n_err  += int'(err_pulse);
                end
            end
            if (!got) check($sformatf("vec%0d_timeout", i), 0, 1);
            tick();
            check($sformatf("vec%0d_pulse_width", i), {done_pulse, err_pulse}, 0);
            check($sformatf("vec%0d_start_fill", i), n_fill, vecs[i].exp_fill);
            check($sformatf("vec%0d_start_blit", i), n_blit, vecs[i].exp_blit);
            check($sformatf("vec%0d_start_at", i), start_at, vecs[i].exp_start_at);
            check($sformatf("vec%0d_done", i), n_done, vecs[i].exp_done);
            check($sformatf("vec%0d_err", i), n_err, vecs[i].exp_err);
            check($sformatf("vec%0d_err_count", i), err_count, vecs[i].exp_errcnt);
            check($sformatf("vec%0d_queue_count", i), queue_count, 0);
            check($sformatf("vec%0d_idle", i), idle, 1);
            if (vecs[i].exp_start_at > 0) begin
                check($sformatf("vec%0d_x1", i), c_x1, vecs[i].x1);
                check($sformatf("vec%0d_x2", i), c_x2, vecs[i].x2);
                check($sformatf("vec%0d_y1", i), c_y1, vecs[i].y1);
                check($sformatf("vec%0d_y2", i), c_y2, vecs[i].y2);
                if (vecs[i].op == 2'd0) check($sformatf("vec%0d_value", i), c_val, vecs[i].val);
                if (vecs[i].op == 2'd1) begin
                    check($sformatf("vec%0d_w", i), c_w, vecs[i].w);
                    check($sformatf("vec%0d_h", i), c_h, vecs[i].h);
                end
            end
        end
        // Operands hold their last issued values after completion.
        check("hold_x2", eng_x2, 511);
        check("hold_y2", eng_y2, 255);

        // Five back-to-back pushes: queue fills to DEPTH, all issue in order.
        model_len = 6;
        model_err = 1'b0;
        mon_x1.delete();
        base_d = mon_done;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(i[0] ? 2'd1 : 2'd0, 9'(i + 1), 9'd8, 8'd1, 8'd2, 1'b1, 9'd3, 8'd4);
            k = 0;
            while (!cmd_ready && k < 100) begin tick(); k++; end
            tick();
        end
        cmd_valid = 1'b0;
        check("b2b_cmd_ready_full", cmd_ready, 0);
        check("b2b_queue_count_full", queue_count, 4);
        wait_done(base_d + 5, 400, "b2b_done");
        tick();
        check("b2b_done_count", mon_done - base_d, 5);
        check("b2b_issued", mon_x1.size(), 5);
        for (int i = 0; i < 5 && i < mon_x1.size(); i++)
            check($sformatf("b2b_order%0d", i), mon_x1[i], i + 1);
        check("b2b_idle", idle, 1);

        // Flush during RUN of the first of three queued commands.
        model_len = 20;
        base_s = mon_starts;
        base_d = mon_done;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(2'd0, 9'(50 + i), 9'd60, 8'd0, 8'd0, 1'b0, 9'd0, 8'd0);
            tick();
        end
        cmd_valid = 1'b0;
        wait_starts(base_s + 1, 50, "flush_first_start");
        tick(); tick(); tick();
        drive_cmd(2'd0, 9'd77, 9'd78, 8'd0, 8'd0, 1'b0, 9'd0, 8'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        check("flush_queue_count", queue_count, 0);
        check("flush_cmd_ready", cmd_ready, 1);
        wait_done(base_d + 1, 100, "flush_done");
        for (int i = 0; i < 10; i++) tick();
        check("flush_starts", mon_starts - base_s, 1);
        check("flush_done_count", mon_done - base_d, 1);
        check("flush_idle", idle, 1);

        // Reset during RUN while the engine is still busy.
        model_len = 15;
        base_s = mon_starts;
        drive_cmd(2'd1, 9'd33, 9'd40, 8'd1, 8'd2, 1'b0, 9'd5, 8'd6);
        tick();
        cmd_valid = 1'b0;
        wait_starts(base_s + 1, 50, "rstrun_start");
        tick(); tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        check("rstrun_eng_x1", eng_x1, 0);
        check("rstrun_err_count", err_count, 0);
        check("rstrun_queue_count", queue_count, 0);
        check("rstrun_busy_still", eng_busy, 1);
        tick();
        rst = 1'b0;
        check("rstrun_cmd_ready", cmd_ready, 1);
        base_s = mon_starts;
        base_d = mon_done;
        drive_cmd(2'd0, 9'd44, 9'd45, 8'd3, 8'd4, 1'b1, 9'd0, 8'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rstrun_no_early_start", mon_starts - base_s, 0);
        wait_starts(base_s + 1, 60, "rstrun_restart");
        wait_done(base_d + 1, 60, "rstrun_done");
        if (mon_x1.size() > 0) check("rstrun_x1", mon_x1[mon_x1.size() - 1], 44);
        check("rstrun_starts", mon_starts - base_s, 1);

        check("start_both", both_viol, 0);
        check("start_consecutive", consec_viol, 0);
        check("start_while_busy", busy_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
